// File: rtl/tft_pkg.sv
// Shared constants for the TFT scan-out path and the page generators that fill the framebuffer.
// Provides the default raster timing, framebuffer extents, RGB565 colours and the fetch FSM states.
package tft_pkg;

   localparam int unsigned H_ACTIVE_DEF = 480;
   localparam int unsigned H_FP_DEF     = 8;
   localparam int unsigned H_SYNC_DEF   = 4;
   localparam int unsigned H_BP_DEF     = 8;
   localparam int unsigned H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

   localparam int unsigned V_ACTIVE_DEF = 800;
   localparam int unsigned V_FP_DEF     = 4;
   localparam int unsigned V_SYNC_DEF   = 2;
   localparam int unsigned V_BP_DEF     = 4;
   localparam int unsigned V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

   localparam int unsigned FRAME_PIXELS   = H_ACTIVE_DEF * V_ACTIVE_DEF;
   localparam int unsigned LAST_QUAD_ADDR = FRAME_PIXELS - 4;

   localparam logic [15:0] Color_Black  = 16'h0000;
   localparam logic [15:0] Color_Red    = 16'hF800;
   localparam logic [15:0] Color_Green  = 16'h07E0;
   localparam logic [15:0] Color_Blue   = 16'h001F;
   localparam logic [15:0] Color_Yellow = 16'hFFE0;
   localparam logic [15:0] Color_Cyan   = 16'h07FF;
   localparam logic [15:0] Color_White  = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      GAP  = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/scanout_quad_fifo.sv
// Prefetch FIFO of 64-bit pixel quads; written a quad at a time, read one RGB565 pixel at a time.
// A quad slot is only released once all four of its pixels have been popped.
module scanout_quad_fifo #(
   parameter int unsigned FIFO_QUADS = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          flush,
   input  logic                          wr_en,
   input  logic [63:0]                   wr_quad,
   input  logic                          rd_pop,
   output logic [15:0]                   rd_pixel,
   output logic                          empty,
   output logic [$clog2(FIFO_QUADS):0]   free_cnt
);

   localparam int unsigned PW = $clog2(FIFO_QUADS);

   logic [63:0] mem [FIFO_QUADS];
   logic [PW:0] wr_ptr;
   logic [PW:0] rd_ptr;
   logic [PW:0] used;
   logic [1:0]  sub;
   logic [63:0] head;

   assign used     = wr_ptr - rd_ptr;
   assign empty    = (used == '0);
   assign free_cnt = (PW+1)'(FIFO_QUADS) - used;
   assign head     = mem[rd_ptr[PW-1:0]];

   always_comb begin
      rd_pixel = head[15:0];
      case (sub)
         2'd0:    rd_pixel = head[15:0];
         2'd1:    rd_pixel = head[31:16];
         2'd2:    rd_pixel = head[47:32];
         default: rd_pixel = head[63:48];
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en && !flush) begin
         mem[wr_ptr[PW-1:0]] <= wr_quad;
      end
   end

   // Write and pop touch independent pointers, so a same-cycle write and pop both land.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         sub    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         sub    <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_pop && !empty) begin
            sub <= sub + 1'b1;
            if (sub == 2'd3) begin
               rd_ptr <= rd_ptr + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/tft_frame_scanout.sv
// Framebuffer scan-out: prefetches pixel quads from SDRAM and drives 480x800 RGB565 TFT timing.
// The FIFO is flushed and fetching restarts from address 0 at vsync start and whenever en is low.
module tft_frame_scanout
   import tft_pkg::*;
#(
   parameter int unsigned H_ACTIVE        = H_ACTIVE_DEF,
   parameter int unsigned H_FP            = H_FP_DEF,
   parameter int unsigned H_SYNC          = H_SYNC_DEF,
   parameter int unsigned H_BP            = H_BP_DEF,
   parameter int unsigned V_ACTIVE        = V_ACTIVE_DEF,
   parameter int unsigned V_FP            = V_FP_DEF,
   parameter int unsigned V_SYNC          = V_SYNC_DEF,
   parameter int unsigned V_BP            = V_BP_DEF,
   parameter int unsigned FIFO_QUADS      = 4,
   parameter logic [15:0] UNDERFLOW_COLOR = Color_Red
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        pix_ce,
   output logic [23:0] oSDRAM_Rd_Addr,
   output logic        oSDRAM_Rd_Req,
   input  logic        iSDRAM_Rd_Done,
   input  logic [15:0] iSDRAM_Data1,
   input  logic [15:0] iSDRAM_Data2,
   input  logic [15:0] iSDRAM_Data3,
   input  logic [15:0] iSDRAM_Data4,
   output logic        tft_hsync,
   output logic        tft_vsync,
   output logic        tft_de,
   output logic [15:0] tft_rgb,
   output logic        oUnderflow
);

   localparam int unsigned HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW = $clog2(HT);
   localparam int unsigned VW = $clog2(VT);
   localparam int unsigned PW = $clog2(FIFO_QUADS);

   localparam logic [HW-1:0] H_DE_END   = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0] H_LAST     = HW'(HT - 1);
   localparam logic [VW-1:0] V_DE_END   = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VW-1:0] V_LAST     = VW'(VT - 1);
   localparam logic [23:0]   LAST_ADDR  = 24'(H_ACTIVE * V_ACTIVE - 4);

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          adv;
   logic          de_now;
   logic          hs_now;
   logic          vs_now;

   fetch_state_t  state;
   logic [23:0]   fetch_addr;
   logic          fetch_end;
   logic          flush_pend;
   logic          flush_set;
   logic          flush_exec;

   logic          fifo_wr;
   logic          fifo_pop;
   logic          fifo_empty;
   logic [15:0]   fifo_pixel;
   logic [PW:0]   fifo_free;

   assign adv    = en & pix_ce;
   assign de_now = (h_cnt < H_DE_END) && (v_cnt < V_DE_END);
   assign hs_now = !((h_cnt >= HS_START) && (h_cnt < HS_END));
   assign vs_now = !((v_cnt >= VS_START) && (v_cnt < VS_END));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (!en) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (pix_ce) begin
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
      end
   end

   assign fifo_pop = adv & de_now & ~fifo_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tft_hsync  <= 1'b1;
         tft_vsync  <= 1'b1;
         tft_de     <= 1'b0;
         tft_rgb    <= '0;
         oUnderflow <= 1'b0;
      end else if (!en) begin
         tft_hsync  <= 1'b1;
         tft_vsync  <= 1'b1;
         tft_de     <= 1'b0;
         tft_rgb    <= '0;
      end else if (pix_ce) begin
         tft_hsync <= hs_now;
         tft_vsync <= vs_now;
         tft_de    <= de_now;
         if (!de_now) begin
            tft_rgb <= '0;
         end else if (fifo_empty) begin
            tft_rgb    <= UNDERFLOW_COLOR;
            oUnderflow <= 1'b1;
         end else begin
            tft_rgb <= fifo_pixel;
         end
      end
   end

   // A flush requested mid-handshake waits for Done; the data is dropped and the flush runs in GAP.
   assign flush_set  = ~en | (adv & (h_cnt == '0) & (v_cnt == VS_START));
   assign flush_exec = flush_pend & (state != REQ);
   assign fifo_wr    = (state == REQ) & iSDRAM_Rd_Done & ~flush_pend;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_pend <= 1'b0;
      end else if (flush_set) begin
         flush_pend <= 1'b1;
      end else if (flush_exec) begin
         flush_pend <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         fetch_addr <= '0;
         fetch_end  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (en && !flush_pend && !fetch_end && (fifo_free != '0)) begin
                  state <= REQ;
               end
            end
            REQ: begin
               if (iSDRAM_Rd_Done) begin
                  state <= GAP;
               end
            end
            GAP:     state <= IDLE;
            default: state <= IDLE;
         endcase

         if (flush_exec) begin
            fetch_addr <= '0;
            fetch_end  <= 1'b0;
         end else if (state == GAP) begin
            if (fetch_addr >= LAST_ADDR) begin
               fetch_end <= 1'b1;
            end else begin
               fetch_addr <= fetch_addr + 24'd4;
            end
         end
      end
   end

   assign oSDRAM_Rd_Req  = (state == REQ);
   assign oSDRAM_Rd_Addr = fetch_addr;

   scanout_quad_fifo #(
      .FIFO_QUADS (FIFO_QUADS)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush_exec),
      .wr_en    (fifo_wr),
      .wr_quad  ({iSDRAM_Data4, iSDRAM_Data3, iSDRAM_Data2, iSDRAM_Data1}),
      .rd_pop   (fifo_pop),
      .rd_pixel (fifo_pixel),
      .empty    (fifo_empty),
      .free_cnt (fifo_free)
   );

endmodule

// File: doc/tft_frame_scanout.md
# tft_frame_scanout

Downstream consumer of the framebuffer that the page generators (power-on self-test, menus) fill in SDRAM. It fetches 4-pixel quads from SDRAM over the read glue handshake into a small prefetch FIFO. It generates 480×800 TFT raster timing and drives one RGB565 pixel per pixel-clock enable. Framebuffer layout is linear: address = line×480 + pixel; each quad is 4 consecutive addresses.

## Interface
Parameters:
- H_ACTIVE, 480, pixels per line
- H_FP / H_SYNC / H_BP, 8 / 4 / 8, horizontal porches and sync width, in pixels
- V_ACTIVE, 800, lines per frame
- V_FP / V_SYNC / V_BP, 4 / 2 / 4, vertical porches and sync width, in lines
- FIFO_QUADS, 4, prefetch depth in quads (power of 2, ≥2)
- UNDERFLOW_COLOR, 16'hF800, pixel driven when the FIFO is empty during DE

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- en  in  1  scan-out enable
- pix_ce  in  1  pixel clock enable; one pixel per high cycle
- oSDRAM_Rd_Addr  out  24  quad start address
- oSDRAM_Rd_Req  out  1  read request
- iSDRAM_Rd_Done  in  1  read complete; data valid in this cycle
- iSDRAM_Data1..4  in  16 each  quad pixels; Data1 is the lowest address
- tft_hsync, tft_vsync  out  1  sync, active-low
- tft_de  out  1  data enable
- tft_rgb  out  16  RGB565 pixel
- oUnderflow  out  1  sticky; set on any underflow pixel

## Operation
- Reset values: oSDRAM_Rd_Addr=0, oSDRAM_Rd_Req=0, tft_hsync=1, tft_vsync=1, tft_de=0, tft_rgb=0, oUnderflow=0. FIFO is empty; h_cnt=v_cnt=0.
- Raster:
  - h_cnt counts 0..H_TOTAL-1; v_cnt counts 0..V_TOTAL-1. Both advance only when pix_ce=1 and en=1.
  - Each axis runs in the order active, FP, sync, BP.
  - hsync=0 for H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync uses the same rule on v_cnt.
  - de = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE).
- Pixel pop: on pix_ce with de=1, pop one pixel in quad order Data1, Data2, Data3, Data4.
  - FIFO empty → drive UNDERFLOW_COLOR, set oUnderflow, no pop.
- Fetch FSM:
  - IDLE: go to REQ when the FIFO has ≥1 free quad slot, fetch_addr ≤ H_ACTIVE×V_ACTIVE−4 (383996), and no flush is pending.
  - REQ: oSDRAM_Rd_Addr=fetch_addr; hold oSDRAM_Rd_Req=1 until iSDRAM_Rd_Done=1.
  - On the Done cycle: write Data1..4 as one FIFO entry, then go to GAP.
  - GAP: Req=0 for exactly one cycle; fetch_addr += 4; return to IDLE.
  - Req never changes address while high. Req never deasserts before Done.
- Frame restart: on the pix_ce cycle where v_cnt enters vsync with h_cnt=0, raise a flush request.
  - If the FSM is in REQ, finish the handshake and discard its data.
  - Then empty the FIFO, set fetch_addr=0, clear the flush, and resume fetching. Vertical blanking refills the FIFO before line 0.
- Arithmetic: fetch_addr is 24-bit. It never exceeds 383996; fetching stops at the frame end until the flush.
- en=0:
  - Counters freeze at 0; outputs go to reset values, except oUnderflow, which holds.
  - An in-flight Req completes its handshake, then the FSM idles.
  - en rising starts from h_cnt=v_cnt=0 with a flushed FIFO.
- Simultaneous write (Done) and pop in one cycle: both take effect; occupancy stays consistent.

## Timing
- tft_hsync, tft_vsync, tft_de and tft_rgb are registered together: they update 1 clk after the pix_ce cycle that produced them and stay mutually aligned.
- Rd_Req rises no earlier than 1 clk after IDLE sees free space. Minimum request spacing is 2 clk (Done cycle + GAP).
- FIFO write-to-readable latency is 1 clk.
- Reset asserted mid-handshake clears Req immediately; the SDRAM glue must tolerate an aborted request.

## Structure
- Shared package tft_pkg holds:
  - timing defaults: H_/V_ constants, H_TOTAL, V_TOTAL
  - FRAME_PIXELS=384000 and LAST_QUAD_ADDR=383996
  - colour constants (Color_Red, Color_White, …), also used by page generators
  - fetch state enum (IDLE, REQ, GAP)
- Sub-module scanout_quad_fifo: FIFO_QUADS×64-bit storage, 2-bit pixel sub-index on the read side, flush input, empty/free-count outputs.

## Test plan
- Reset, en=1, pix_ce every cycle, SDRAM model with Done 3 clk after Req → first requests use addresses 0, 4, 8, 12; FIFO fills to 4 quads and Req stays low while full.
- Framebuffer pattern pixel[a]=a[15:0] → every DE pixel of line L, column c equals (L×480+c)[15:0]; hsync/vsync widths are 4 and 2 as per parameters; 480 DE pixels per line, 800 lines.
- SDRAM Done delayed 40 clk, pix_ce every cycle → UNDERFLOW_COLOR 16'hF800 appears on DE and oUnderflow=1 sticks into the next frame.
- vsync start arrives while Req is high → Req held until Done, that data discarded, next Req address is 0.
- en dropped for 100 clk mid-line, then raised → outputs idle during the gap; next frame starts at pixel address 0 with correct content.
- Async reset pulse during REQ → all outputs at reset values within the same cycle; restart fetches from 0.
